// File: rtl/servo_pkg.sv
// servo_pkg
// Shared definitions for the servo PWM generator and capture blocks:
// default timing constants, the clock-ticks-per-microsecond helper and
// the capture FSM state type.
package servo_pkg;

  localparam int DEFAULT_CLK_HZ             = 50_000_000;
  localparam int DEFAULT_PULSE_SIGNAL_US    = 20_000;
  localparam int DEFAULT_MIN_PULSE_WIDTH_US = 1_000;
  localparam int DEFAULT_MAX_PULSE_WIDTH_US = 2_000;

  // Clock frequency must be a whole number of MHz for this to be exact.
  function automatic int ticks_per_us(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  typedef enum logic [1:0] {
    ARM,
    WAIT_RISE,
    HIGH
  } cap_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
// Two-flop synchroniser for an asynchronous level plus a one-cycle-delayed
// copy, giving single-cycle rise/fall strobes in the clk domain.
// Ports:
//   clk    : system clock
//   rst    : asynchronous active-high reset (all flops to 0)
//   raw    : asynchronous input level
//   synced : synchronised level
//   rise   : one-cycle strobe, synced went 0 -> 1
//   fall   : one-cycle strobe, synced went 1 -> 0
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic synced,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta   <= raw;
      sync_q <= meta;
      prev_q <= sync_q;
    end
  end

  assign synced = sync_q;
  assign rise   = sync_q & ~prev_q;
  assign fall   = ~sync_q & prev_q;

endmodule

// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture
// Measures the high time of an RC/servo PWM input in microseconds and
// publishes one validated width per frame. Out-of-range pulses raise a
// one-cycle range_err instead, and lack of rising edges for TIMEOUT_US
// raises signal_lost until the next accepted pulse.
// Ports:
//   clk         : system clock (CLK_HZ)
//   rst         : asynchronous active-high reset
//   pwm_in      : asynchronous PWM input
//   width_us    : last accepted pulse width in microseconds
//   valid       : one-cycle strobe, width_us was just updated
//   range_err   : one-cycle strobe, completed pulse was outside [MIN, MAX]
//   signal_lost : level, no rising edge seen for TIMEOUT_US
module servo_pwm_capture
  import servo_pkg::*;
#(
  parameter int CLK_HZ             = DEFAULT_CLK_HZ,
  parameter int PULSE_SIGNAL_US    = DEFAULT_PULSE_SIGNAL_US,
  parameter int MIN_PULSE_WIDTH_US = DEFAULT_MIN_PULSE_WIDTH_US,
  parameter int MAX_PULSE_WIDTH_US = DEFAULT_MAX_PULSE_WIDTH_US,
  parameter int TIMEOUT_US         = 2 * PULSE_SIGNAL_US
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [15:0] width_us,
  output logic        valid,
  output logic        range_err,
  output logic        signal_lost
);

  localparam int TICKS_PER_US = ticks_per_us(CLK_HZ);
  localparam int PW  = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int PW1 = PW + 1;

  localparam logic [PW-1:0] PRESC_LAST     = PW'(TICKS_PER_US - 1);
  localparam logic [PW:0]   HALF_TICKS     = PW1'(TICKS_PER_US / 2);
  localparam logic [16:0]   TIMEOUT_LIMIT  = 17'(TIMEOUT_US);
  localparam logic [16:0]   TIMEOUT_BEFORE = 17'(TIMEOUT_US - 1);
  localparam logic [16:0]   MIN_W          = 17'(MIN_PULSE_WIDTH_US);
  localparam logic [16:0]   MAX_W          = 17'(MAX_PULSE_WIDTH_US);

  logic          synced;
  logic          rise;
  logic          fall;
  logic [PW-1:0] presc;
  logic          us_tick;
  logic [15:0]   high_us;
  logic [16:0]   idle_us;
  logic [1:0]    settle;
  logic          settled;
  logic          timeout_hit;
  logic [PW:0]   ticks_in_us;
  logic [16:0]   width_round;
  logic          in_range;
  logic          report_valid;
  logic          report_err;
  cap_state_t    state;
  cap_state_t    state_next;

  sync_edge_detect u_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (pwm_in),
    .synced (synced),
    .rise   (rise),
    .fall   (fall)
  );

  // A rise restarts the microsecond grid, so no tick is issued on that cycle.
  assign us_tick = ~rise && (presc == PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (rise || presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_us <= '0;
      idle_us <= '0;
    end else if (rise) begin
      high_us <= '0;
      idle_us <= '0;
    end else if (us_tick) begin
      if (synced && high_us != 16'hFFFF) begin
        high_us <= high_us + 16'd1;
      end
      if (idle_us < TIMEOUT_LIMIT) begin
        idle_us <= idle_us + 17'd1;
      end
    end
  end

  // The synchroniser needs a few cycles after reset before synced/prev
  // reflect the pin; ARM must not treat the reset value 0 as a real low,
  // otherwise a pulse already in progress would be reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle <= '0;
    end else if (settle != 2'd3) begin
      settle <= settle + 2'd1;
    end
  end

  assign settled = (settle == 2'd3);

  // Loss is an event at the moment idle_us reaches the limit; idle_us then
  // saturates so the FSM is not pushed back to ARM every cycle.
  assign timeout_hit = us_tick && (idle_us == TIMEOUT_BEFORE);

  // The fall cycle itself is one more elapsed tick not yet in presc, which
  // makes the half-microsecond comparison land exactly on round-half-up.
  assign ticks_in_us = {1'b0, presc} + PW1'(1);
  assign width_round = {1'b0, high_us} + ((ticks_in_us >= HALF_TICKS) ? 17'd1 : 17'd0);
  assign in_range    = (width_round >= MIN_W) && (width_round <= MAX_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    report_valid = 1'b0;
    report_err   = 1'b0;
    if (timeout_hit) begin
      state_next = ARM;
    end else begin
      case (state)
        ARM: begin
          if (settled && !synced) begin
            state_next = WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            state_next = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            if (in_range) begin
              report_valid = 1'b1;
            end else begin
              report_err = 1'b1;
            end
            state_next = WAIT_RISE;
          end
        end
        default: begin
          state_next = ARM;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_us    <= '0;
      valid       <= 1'b0;
      range_err   <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      valid     <= report_valid;
      range_err <= report_err;
      if (report_valid) begin
        width_us <= width_round[15:0];
      end
      if (timeout_hit) begin
        signal_lost <= 1'b1;
      end else if (report_valid) begin
        signal_lost <= 1'b0;
      end
    end
  end

endmodule
